// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between several valid/ready producers.
// A grant lasts one burst: until a beat with last is written or MaxBurst beats are written.
module fifo_write_arbiter #(
    parameter int Width      = 8,
    parameter int Requesters = 4,
    parameter int MaxBurst   = 4,
    localparam int IdW       = $clog2(Requesters),
    localparam int CntW      = $clog2(MaxBurst + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [Requesters-1:0]         req_valid,
    input  logic [Requesters*Width-1:0]   req_data,
    input  logic [Requesters-1:0]         req_last,
    output logic [Requesters-1:0]         req_ready,
    output logic                          fifo_write_enable,
    output logic [Width-1:0]              fifo_write_data,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [IdW-1:0]                grant_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            grant_valid_next;
    logic [IdW-1:0]  grant_id_next;
    logic [IdW-1:0]  last_grant;
    logic [IdW-1:0]  last_grant_next;
    logic [CntW-1:0] beat_count;
    logic [CntW-1:0] beat_count_next;

    logic            cur_valid;
    logic            cur_last;
    logic            transfer;
    logic            do_release;
    logic            pick_found;
    logic [IdW-1:0]  pick_id;
    logic [IdW-1:0]  cand;

    assign cur_valid         = req_valid[grant_id];
    assign cur_last          = req_last[grant_id];
    assign transfer          = grant_valid & cur_valid & ~fifo_full;
    assign fifo_write_enable = transfer;
    assign fifo_write_data   = req_data[grant_id*Width +: Width];

    // Ready is offered to the granted requester whenever the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Scan starts just after the last released requester, so it gets lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = last_grant;
        cand       = '0;
        for (int k = 1; k <= Requesters; k++) begin
            cand = IdW'((int'(last_grant) + k) % Requesters);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next       = state;
        grant_valid_next = grant_valid;
        grant_id_next    = grant_id;
        beat_count_next  = beat_count;
        last_grant_next  = last_grant;
        do_release       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next       = GRANT;
                    grant_valid_next = 1'b1;
                    grant_id_next    = pick_id;
                    beat_count_next  = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    if (cur_last || beat_count == CntW'(MaxBurst - 1)) begin
                        do_release = 1'b1;
                    end else begin
                        beat_count_next = beat_count + 1'b1;
                    end
                end else if (!fifo_full && beat_count == '0 && !cur_valid) begin
                    // Requester withdrew before its first beat; a started burst is never abandoned.
                    do_release = 1'b1;
                end
                if (do_release) begin
                    state_next       = IDLE;
                    grant_valid_next = 1'b0;
                    last_grant_next  = grant_id;
                    beat_count_next  = '0;
                end
            end
            default: begin
                state_next       = IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            beat_count  <= '0;
            last_grant  <= IdW'(Requesters - 1);
        end else begin
            state       <= state_next;
            grant_valid <= grant_valid_next;
            grant_id    <= grant_id_next;
            beat_count  <= beat_count_next;
            last_grant  <= last_grant_next;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a `fifo` instance between `Requesters` independent producers.
- Each producer presents a valid/ready stream with a `last` marker.
- A grant is held for one burst: until `last` is transferred or `MaxBurst` beats are written, so short packets land contiguously in the FIFO.
- Sits directly in front of the FIFO: drives `write_enable` and `write_data`, and observes `full`.

Parameters:
- Width, 8: data width per beat; must match the FIFO `Width`.
- Requesters, 4: number of producers, at least 2.
- MaxBurst, 4: maximum beats per grant before forced rotation, at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  Requesters  per-requester beat valid
- req_data  in  Requesters*Width  requester i data at bits [i*Width +: Width]
- req_last  in  Requesters  per-requester end-of-burst marker, qualified by valid
- req_ready  out  Requesters  per-requester beat accepted
- fifo_write_enable  out  1  to FIFO `write_enable`
- fifo_write_data  out  Width  to FIFO `write_data`
- fifo_full  in  1  from FIFO `full`
- grant_valid  out  1  a requester currently holds the port
- grant_id  out  $clog2(Requesters)  index of the granted requester

Behaviour:
- Reset (synchronous, wins over all else):
  - state=IDLE, grant_valid=0, grant_id=0, beat_count=0.
  - last_grant=Requesters-1, so requester 0 has first priority.
  - All outputs go low at the next edge; an in-flight burst is abandoned and no partial-beat state is kept.
- Definitions:
  - transfer = grant_valid & req_valid[grant_id] & !fifo_full.
  - req_ready[i] = grant_valid & (grant_id==i) & !fifo_full, combinational.
  - All other ready bits are 0.
  - fifo_write_enable = transfer.
  - fifo_write_data = req_data slice of grant_id; it is don't-care when not transferring but is always driven from the mux.
- `full` is treated conservatively: no write is issued while fifo_full=1, even if the FIFO is being read in the same cycle.
- IDLE:
  - If any req_valid bit is set, select the first set bit scanning last_grant+1, last_grant+2, … with modulo-Requesters wrap.
  - At the next edge: grant_id=selected, grant_valid=1, beat_count=0, state=GRANT.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
  - If no bit is set, stay in IDLE.
- GRANT:
  - Each transfer increments beat_count, which saturates logic at MaxBurst and is $clog2(MaxBurst+1) bits wide.
  - Release at the edge of a transfer with req_last[grant_id]=1.
  - Release at the edge of a transfer that makes beat_count==MaxBurst.
  - Release at the edge of a cycle where beat_count==0 and req_valid[grant_id]=0 (requester withdrew before its first beat).
  - Once beat_count>0, dropping valid does not release; the grant is held until `last` or MaxBurst.
  - While fifo_full=1, the grant is held and beat_count does not change.
  - On release: state=IDLE, grant_valid=0, last_grant=grant_id, beat_count=0.
  - There is one bubble cycle between consecutive grants.
- Fairness:
  - A requester that just released has the lowest priority in the next arbitration.
  - Under continuous load each requester gets at most MaxBurst beats per rotation.
- Simultaneous events:
  - A transfer with last at the MaxBurst boundary is one release, not two.
  - req_valid changes on non-granted requesters never affect the current grant.
  - Requester data ordering within a burst is preserved.
- Throughput: with one requester streaming and MaxBurst=4, the pattern is 4 writes then 1 idle cycle.

Test Plan:
- Reset then idle: all req_valid=0 for 10 cycles -> grant_valid=0, fifo_write_enable=0, all req_ready=0.
- Single requester, 3 beats 0x11, 0x22, 0x33 (last on 0x33) from req 2:
  - grant_id=2 one cycle after valid.
  - FIFO receives 11, 22, 33 on consecutive cycles.
  - grant drops after 0x33.
- All 4 requesters valid continuously with no last, MaxBurst=4 -> grants in order 0, 1, 2, 3, 0, each exactly 4 writes, 1 bubble between.
- fifo_full asserted for 3 cycles mid-burst after beat 2 of req 1:
  - req_ready=0 and no write during those cycles.
  - beat_count stays 2.
  - Beats 3–4 complete after full drops, then release.
- Req 3 granted, then deasserts valid before any beat while req 0 is valid -> release next edge, last_grant=3, req 0 granted next.
- Reset asserted mid-burst (beat 2 of 4) -> next edge grant_valid=0, fifo_write_enable=0; the following arbitration favours req 0.
